demux4_stream: RTL and testbench

//   1-to-4 stream demultiplexer: the inverse of the 4-to-1 select path. One

---
 rtl/demux4_stream_if.sv | 25 ++
 rtl/demux4_stream.sv | 61 ++++++
 tb/tb_demux4_stream.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/demux4_stream_if.sv
// demux4_stream_if: producer-side stream plus the four lane outputs of the demux.
interface demux4_stream_if #(
    parameter int N = 32
);
    logic [N-1:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data0;
    logic [N-1:0] out_data1;
    logic [N-1:0] out_data2;
    logic [N-1:0] out_data3;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data0, out_data1, out_data2, out_data3, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data0, out_data1, out_data2, out_data3, out_valid
    );
endinterface

// File: rtl/demux4_stream.sv
// demux4_stream: steers one valid/ready stream into four per-lane FIFOs of DEPTH entries.
// A stalled lane only blocks beats addressed to itself.
module demux4_stream #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input logic            clk,
    input logic            rst,
    demux4_stream_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]   w_full;
    logic [3:0]   w_push;
    logic [3:0]   w_pop;
    logic         w_in_ready;
    logic [N-1:0] w_head [4];

    // Full flags come from registered counts, so in_ready never sees out_ready.
    assign w_in_ready   = !w_full[bus.in_sel];
    assign bus.in_ready = w_in_ready;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_lane
            logic [CW-1:0] r_count;
            logic [AW-1:0] r_wr_ptr;
            logic [AW-1:0] r_rd_ptr;
            logic [N-1:0]  r_mem [DEPTH];

            assign w_full[k]        = (r_count == CW'(DEPTH));
            assign w_push[k]        = bus.in_valid & w_in_ready & (bus.in_sel == 2'(k));
            assign w_pop[k]         = bus.out_valid[k] & bus.out_ready[k];
            assign bus.out_valid[k] = (r_count != '0);
            assign w_head[k]        = r_mem[r_rd_ptr];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_count  <= '0;
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
                end else begin
                    if (w_push[k]) begin
                        r_mem[r_wr_ptr] <= bus.in_data;
                        r_wr_ptr        <= r_wr_ptr + AW'(1);
                    end
                    if (w_pop[k]) r_rd_ptr <= r_rd_ptr + AW'(1);
                    if (w_push[k] && !w_pop[k]) r_count <= r_count + CW'(1);
                    else if (w_pop[k] && !w_push[k]) r_count <= r_count - CW'(1);
                end
            end
        end
    endgenerate

    assign bus.out_data0 = w_head[0];
    assign bus.out_data1 = w_head[1];
    assign bus.out_data2 = w_head[2];
    assign bus.out_data3 = w_head[3];
endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: vector table, directed corner sequences and a queue-model random run.
module tb_demux4_stream;
    localparam int N     = 32;
    localparam int DEPTH = 2;

    logic clk = 0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    demux4_stream_if #(.N(N)) bus ();

    demux4_stream #(.N(N), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        in_valid;
        logic [1:0]  in_sel;
        logic [31:0] in_data;
        logic [3:0]  out_ready;
        logic        exp_ready;
        logic [3:0]  exp_valid;
        int          lane;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vt [12];
    logic [31:0] q [4][$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    function automatic logic [31:0] lane_data(input int k);
        return k == 0 ? bus.out_data0 : k == 1 ? bus.out_data1 :
               k == 2 ? bus.out_data2 : bus.out_data3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
    endtask

    initial begin
        vt[0]  = '{1'b1, 2'd0, 32'hA0, 4'hF, 1'b1, 4'b0001, 0, 32'hA0};
        vt[1]  = '{1'b1, 2'd1, 32'hA1, 4'hF, 1'b1, 4'b0010, 1, 32'hA1};
        vt[2]  = '{1'b1, 2'd2, 32'hA2, 4'hF, 1'b1, 4'b0100, 2, 32'hA2};
        vt[3]  = '{1'b1, 2'd3, 32'hA3, 4'hF, 1'b1, 4'b1000, 3, 32'hA3};
        vt[4]  = '{1'b0, 2'd0, 32'h0,  4'hF, 1'b1, 4'b0000, -1, 32'h0};
        vt[5]  = '{1'b1, 2'd2, 32'h10, 4'hB, 1'b1, 4'b0100, 2, 32'h10};
        vt[6]  = '{1'b1, 2'd2, 32'h11, 4'hB, 1'b1, 4'b0100, 2, 32'h10};
        vt[7]  = '{1'b1, 2'd2, 32'h12, 4'hB, 1'b0, 4'b0100, 2, 32'h10};
        vt[8]  = '{1'b1, 2'd1, 32'h20, 4'hB, 1'b1, 4'b0110, 1, 32'h20};
        vt[9]  = '{1'b1, 2'd2, 32'h12, 4'hF, 1'b0, 4'b0100, 2, 32'h11};
        vt[10] = '{1'b1, 2'd2, 32'h12, 4'hF, 1'b1, 4'b0100, 2, 32'h12};
        vt[11] = '{1'b0, 2'd0, 32'h0,  4'hF, 1'b1, 4'b0000, -1, 32'h0};

        // Reset held two cycles while the producer keeps offering a beat.
        rst = 1;
        drive(1'b1, 2'd0, 32'hDEAD, 4'h0);
        tick();
        tick();
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        for (int k = 0; k < 4; k++) chk("rst_data", lane_data(k), 32'h0);
        rst = 0;
        drive(1'b0, 2'd0, 32'h0, 4'h0);
        chk("rst_ready", 32'(bus.in_ready), 32'h1);
        tick();
        chk("rst_no_accept", 32'(bus.out_valid), 32'h0);

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].in_valid, vt[i].in_sel, vt[i].in_data, vt[i].out_ready);
            chk($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'(vt[i].exp_ready));
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].exp_valid));
            if (vt[i].lane >= 0)
                chk($sformatf("vec%0d_data", i), lane_data(vt[i].lane), vt[i].exp_data);
        end

        // Lane 0 held at one entry with a push and a pop every cycle.
        drive(1'b1, 2'd0, 32'h100, 4'h0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 2'd0, 32'h101 + 32'(i), 4'h1);
            chk("pp_ready", 32'(bus.in_ready), 32'h1);
            chk("pp_data", bus.out_data0, 32'h100 + 32'(i));
            tick();
            chk("pp_valid", 32'(bus.out_valid), 32'h1);
        end
        chk("pp_last", bus.out_data0, 32'h114);
        drive(1'b0, 2'd0, 32'h0, 4'h1);
        tick();
        chk("pp_drained", 32'(bus.out_valid), 32'h0);

        // Lanes 0 and 3 filled, then a one-cycle reset discards them.
        drive(1'b1, 2'd0, 32'h50, 4'h0); tick();
        drive(1'b1, 2'd0, 32'h51, 4'h0); tick();
        drive(1'b1, 2'd3, 32'h53, 4'h0); tick();
        drive(1'b1, 2'd3, 32'h54, 4'h0);
        tick();
        chk("mid_full_valid", 32'(bus.out_valid), 32'h9);
        drive(1'b1, 2'd0, 32'h55, 4'h0);
        chk("mid_full_ready", 32'(bus.in_ready), 32'h0);
        rst = 1;
        drive(1'b0, 2'd0, 32'h0, 4'h0);
        tick();
        rst = 0;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_d0", bus.out_data0, 32'h0);
        chk("mid_rst_d3", bus.out_data3, 32'h0);
        drive(1'b0, 2'd0, 32'h0, 4'hF);
        tick();
        chk("mid_rst_gone", 32'(bus.out_valid), 32'h0);

        // Random traffic against per-lane FIFO queues.
        rst = 1;
        drive(1'b0, 2'd0, 32'h0, 4'h0);
        tick();
        rst = 0;
        for (int c = 0; c < 10000; c++) begin
            logic acc;
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, 4'($urandom));
            acc = bus.in_valid && (q[bus.in_sel].size() < DEPTH);
            chk("rnd_ready", 32'(bus.in_ready), 32'(q[bus.in_sel].size() < DEPTH));
            for (int k = 0; k < 4; k++) begin
                chk("rnd_valid", 32'(bus.out_valid[k]), 32'(q[k].size() != 0));
                if (q[k].size() != 0) chk("rnd_data", lane_data(k), q[k][0]);
            end
            for (int k = 0; k < 4; k++)
                if (q[k].size() != 0 && bus.out_ready[k]) void'(q[k].pop_front());
            if (acc) q[bus.in_sel].push_back(bus.in_data);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
